// File: rtl/l2_write_buffer_pkg.sv
// Shared types for the L2 victim write buffer.
//   lc3b_word      : 16-bit byte address
//   lc3b_data      : 128-bit cache line
//   lc3b_line_addr : line address, address[15:4]
//   lc3b_wb_state  : write-buffer controller states
package l2_write_buffer_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_data;
   typedef logic [11:0]  lc3b_line_addr;

   typedef enum logic [1:0] {
      StIdle,
      StResp,
      StReadMem,
      StDrain
   } lc3b_wb_state;

   // Line-aligned byte address for a line address.
   function automatic lc3b_word line_base(input lc3b_line_addr line);
      return {line, 4'h0};
   endfunction

endpackage

// File: rtl/l2_write_buffer_fifo.sv
// l2_wb_fifo: circular store of {line address, line data} for the write buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enq, enq_addr/data  push a new line at the tail (caller guarantees not full)
//   ovw, ovw_data       overwrite the data of the entry matching lookup_addr
//   pop                 retire the head entry (caller guarantees not empty)
//   lookup_addr         line address compared against every valid entry
//   hit, hit_data       match result and the matching entry's data
//   head_addr/data      oldest entry, the next one to drain
//   empty, full         count==0 / count==DEPTH
module l2_wb_fifo
   import l2_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enq,
   input  lc3b_line_addr enq_addr,
   input  lc3b_data      enq_data,
   input  logic          ovw,
   input  lc3b_data      ovw_data,
   input  logic          pop,
   input  lc3b_line_addr lookup_addr,
   output logic          hit,
   output lc3b_data      hit_data,
   output lc3b_line_addr head_addr,
   output lc3b_data      head_data,
   output logic          empty,
   output logic          full
);

   lc3b_line_addr    addr_q [DEPTH];
   lc3b_data         data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] match;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   count_q;

   always_comb begin
      match = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         match[i] = valid_q[i] && (addr_q[i] == lookup_addr);
      end
   end

   // Resident addresses are unique, so OR-ing the masked entries selects the hit.
   always_comb begin
      hit_data = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (match[i]) begin
            hit_data = hit_data | data_q[i];
         end
      end
   end

   assign hit       = |match;
   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == (PTR_W + 1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (enq) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         unique case ({enq, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload needs no reset: valid_q gates every use of it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (enq && (tail_q == PTR_W'(i))) begin
            addr_q[i] <= enq_addr;
            data_q[i] <= enq_data;
         end else if (ovw && match[i]) begin
            data_q[i] <= ovw_data;
         end
      end
   end

endmodule

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: victim write buffer between the L2 pmem port and memory.
// Absorbs writebacks, drains them when idle, forwards reads of resident lines.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   l2_read, l2_write                L2 requests, held until l2_resp
//   l2_address, l2_wdata             request line address / writeback data
//   l2_rdata, l2_resp                read data and one-cycle completion pulse
//   pmem_read, pmem_write            memory requests (never both high)
//   pmem_address, pmem_wdata         memory line address / drained line
//   pmem_rdata, pmem_resp            memory read data / completion
//   buf_empty, buf_full              buffer occupancy flags
module l2_write_buffer
   import l2_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     l2_read,
   input  logic     l2_write,
   input  lc3b_word l2_address,
   input  lc3b_data l2_wdata,
   output lc3b_data l2_rdata,
   output logic     l2_resp,
   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_address,
   output lc3b_data pmem_wdata,
   input  lc3b_data pmem_rdata,
   input  logic     pmem_resp,
   output logic     buf_empty,
   output logic     buf_full
);

   lc3b_wb_state  state_q;
   lc3b_data      rdata_q;
   lc3b_line_addr req_line;
   logic          unused_addr_bits;

   logic          hit;
   lc3b_data      hit_data;
   lc3b_line_addr head_addr;
   lc3b_data      head_data;
   logic          empty;
   logic          full;
   logic          idle_write;
   logic          fifo_enq;
   logic          fifo_ovw;
   logic          fifo_pop;

   assign req_line         = l2_address[15:4];
   assign unused_addr_bits = ^l2_address[3:0];

   // A read takes priority over a simultaneous write.
   assign idle_write = (state_q == StIdle) && !l2_read && l2_write;
   assign fifo_ovw   = idle_write && hit;
   assign fifo_enq   = idle_write && !hit && !full;
   assign fifo_pop   = (state_q == StDrain) && pmem_resp;

   l2_wb_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .enq         (fifo_enq),
      .enq_addr    (req_line),
      .enq_data    (l2_wdata),
      .ovw         (fifo_ovw),
      .ovw_data    (l2_wdata),
      .pop         (fifo_pop),
      .lookup_addr (req_line),
      .hit         (hit),
      .hit_data    (hit_data),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .empty       (empty),
      .full        (full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (l2_read) begin
                  if (hit) begin
                     rdata_q <= hit_data;
                     state_q <= StResp;
                  end else begin
                     // Misses may bypass buffered writes: addresses cannot collide.
                     state_q <= StReadMem;
                  end
               end else if (l2_write) begin
                  // Full with no match: drain one entry, the write stays pending.
                  state_q <= (hit || !full) ? StResp : StDrain;
               end else if (!empty) begin
                  state_q <= StDrain;
               end
            end
            StReadMem: begin
               if (pmem_resp) begin
                  rdata_q <= pmem_rdata;
                  state_q <= StResp;
               end
            end
            StDrain: begin
               if (pmem_resp) begin
                  state_q <= StIdle;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      l2_resp      = 1'b0;
      l2_rdata     = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      unique case (state_q)
         StResp: begin
            l2_resp  = 1'b1;
            l2_rdata = rdata_q;
         end
         StReadMem: begin
            pmem_read    = 1'b1;
            pmem_address = line_base(req_line);
         end
         StDrain: begin
            pmem_write   = 1'b1;
            pmem_address = line_base(head_addr);
            pmem_wdata   = head_data;
         end
         default: ;
      endcase
   end

   assign buf_empty = empty;
   assign buf_full  = full;

endmodule

// File: tb/tb_l2_write_buffer.sv
module tb_l2_write_buffer;
   import l2_write_buffer_pkg::*;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   logic     l2_read = 1'b0;
   logic     l2_write = 1'b0;
   lc3b_word l2_address = '0;
   lc3b_data l2_wdata = '0;
   lc3b_data l2_rdata;
   logic     l2_resp;
   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_data pmem_wdata;
   lc3b_data pmem_rdata = '0;
   logic     pmem_resp = 1'b0;
   logic     buf_empty;
   logic     buf_full;

   always #5 clk = ~clk;

   l2_write_buffer #(.DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .l2_read      (l2_read),
      .l2_write     (l2_write),
      .l2_address   (l2_address),
      .l2_wdata     (l2_wdata),
      .l2_rdata     (l2_rdata),
      .l2_resp      (l2_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .buf_empty    (buf_empty),
      .buf_full     (buf_full)
   );

   int n_checks = 0;
   int n_fail = 0;

   // Memory model state
   int   mem_lat = 2;
   logic mem_hold = 1'b0;
   int   busy = 0;
   int   rd_cycles = 0;
   int   both_high = 0;
   logic [15:0]  wr_addr_log[$];
   logic [127:0] wr_data_log[$];
   logic [15:0]  rd_addr_log[$];

   localparam logic [127:0] DA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   localparam logic [127:0] DB = 128'hbbbb_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [127:0] DB2 = 128'hb2b2_b2b2_0000_ffff_1234_5678_9abc_def0;
   localparam logic [127:0] D1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
   localparam logic [127:0] D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
   localparam logic [127:0] D3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
   localparam logic [127:0] DC = 128'hcccc_cccc_cccc_cccc_0000_0000_0000_0000;
   localparam logic [127:0] DD = 128'hdddd_dddd_dddd_dddd_0000_0000_0000_0001;
   localparam logic [127:0] DE = 128'heeee_eeee_eeee_eeee_eeee_eeee_eeee_eeee;

   function automatic logic [127:0] rd_pattern(input logic [15:0] a);
      return {8{a}};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: pmem_resp rises in the mem_lat-th cycle of a request.
   task automatic mem_step();
      if (pmem_read && pmem_write) both_high++;
      if (pmem_read) rd_cycles++;
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
         busy = 0;
      end else if (!mem_hold) begin
         busy++;
         if (busy >= mem_lat) begin
            busy = 0;
            pmem_resp = 1'b1;
            if (pmem_read) begin
               pmem_rdata = rd_pattern(pmem_address);
               rd_addr_log.push_back(pmem_address);
            end else begin
               wr_addr_log.push_back(pmem_address);
               wr_data_log.push_back(pmem_wdata);
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      mem_step();
   endtask

   // Latency counts the request cycle as 1; returns once the DUT is back in idle.
   task automatic wait_resp(output int lat, output logic [127:0] data, output logic pm);
      bit seen;
      seen = 0;
      lat  = 1;
      data = '0;
      pm   = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         cycle();
         lat++;
         if (l2_resp) begin
            seen = 1;
            data = l2_rdata;
            pm   = pmem_read | pmem_write;
         end
      end
      check("resp_timeout", 128'(seen), 128'd1);
      l2_read  = 1'b0;
      l2_write = 1'b0;
      cycle();
   endtask

   task automatic l2_req(input logic is_rd, input logic [15:0] addr, input logic [127:0] wd,
                         output int lat, output logic [127:0] data, output logic pm);
      l2_read    = is_rd;
      l2_write   = !is_rd;
      l2_address = addr;
      l2_wdata   = wd;
      wait_resp(lat, data, pm);
   endtask

   task automatic drain_all();
      bit done;
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         cycle();
         if (buf_empty && !pmem_write && !pmem_read) done = 1;
      end
      check("drain_timeout", 128'(done), 128'd1);
   endtask

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_addr_log.delete();
   endtask

   typedef struct {
      logic         is_rd;
      logic [15:0]  addr;
      logic [127:0] wdata;
      int           exp_lat;
      logic [127:0] exp_rdata;
      logic         exp_empty;
      logic         exp_full;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int           lat;
      logic [127:0] data;
      logic         pm;
      bit           early;

      // Buffer-hit transactions complete 2 cycles after request; a miss with mem_lat=2
      // takes request cycle + 2 memory cycles + response cycle = 4.
      vecs[0] = '{1'b0, 16'h1230, DA,  2, '0,                      1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'h123F, '0,  2, DA,                      1'b0, 1'b0};
      vecs[2] = '{1'b0, 16'h4560, DB,  2, '0,                      1'b0, 1'b1};
      vecs[3] = '{1'b1, 16'h4565, '0,  2, DB,                      1'b0, 1'b1};
      vecs[4] = '{1'b0, 16'h4568, DB2, 2, '0,                      1'b0, 1'b1};
      vecs[5] = '{1'b1, 16'h4560, '0,  2, DB2,                     1'b0, 1'b1};
      vecs[6] = '{1'b1, 16'h8884, '0,  4, rd_pattern(16'h8880),   1'b0, 1'b1};

      // Reset then idle
      cycle();
      cycle();
      rst = 1'b0;
      repeat (5) cycle();
      check("rst_empty", 128'(buf_empty), 128'd1);
      check("rst_full", 128'(buf_full), 128'd0);
      check("rst_pmem_read", 128'(pmem_read), 128'd0);
      check("rst_pmem_write", 128'(pmem_write), 128'd0);
      check("rst_resp", 128'(l2_resp), 128'd0);
      check("rst_rdata", l2_rdata, 128'd0);
      check("rst_pmem_addr", 128'(pmem_address), 128'd0);

      // Table-driven transactions, applied back to back so no drain slips in
      clear_logs();
      for (int i = 0; i < 7; i++) begin
         l2_req(vecs[i].is_rd, vecs[i].addr, vecs[i].wdata, lat, data, pm);
         check($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
         if (vecs[i].is_rd) check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
         check($sformatf("vec%0d_pmem_at_resp", i), 128'(pm), 128'd0);
         check($sformatf("vec%0d_empty", i), 128'(buf_empty), 128'(vecs[i].exp_empty));
         check($sformatf("vec%0d_full", i), 128'(buf_full), 128'(vecs[i].exp_full));
      end
      check("vec_rd_addr", 128'(rd_addr_log[0]), 128'h8880);
      drain_all();
      check("vec_drain_n", 128'(wr_addr_log.size()), 128'd2);
      check("vec_drain0_addr", 128'(wr_addr_log[0]), 128'h1230);
      check("vec_drain0_data", wr_data_log[0], DA);
      check("vec_drain1_addr", 128'(wr_addr_log[1]), 128'h4560);
      check("vec_drain1_data", wr_data_log[1], DB2);
      check("vec_empty_after", 128'(buf_empty), 128'd1);

      // Write to a full buffer waits for one drain
      clear_logs();
      l2_req(1'b0, 16'h1000, D1, lat, data, pm);
      l2_req(1'b0, 16'h2000, D2, lat, data, pm);
      check("full_flag", 128'(buf_full), 128'd1);
      mem_hold   = 1'b1;
      l2_write   = 1'b1;
      l2_address = 16'h3000;
      l2_wdata   = D3;
      early      = 0;
      repeat (4) begin
         cycle();
         if (l2_resp) early = 1;
      end
      check("full_no_resp", 128'(early), 128'd0);
      check("full_drain_wr", 128'(pmem_write), 128'd1);
      check("full_drain_addr", 128'(pmem_address), 128'h1000);
      check("full_drain_data", pmem_wdata, D1);
      mem_hold = 1'b0;
      wait_resp(lat, data, pm);
      drain_all();
      check("order_n", 128'(wr_addr_log.size()), 128'd3);
      check("order0", 128'(wr_addr_log[0]), 128'h1000);
      check("order1", 128'(wr_addr_log[1]), 128'h2000);
      check("order2", 128'(wr_addr_log[2]), 128'h3000);
      check("order2_data", wr_data_log[2], D3);

      // Coalescing writes to the same line
      clear_logs();
      l2_req(1'b0, 16'h7770, DC, lat, data, pm);
      l2_req(1'b0, 16'h7770, DD, lat, data, pm);
      check("coal_full", 128'(buf_full), 128'd0);
      check("coal_empty", 128'(buf_empty), 128'd0);
      drain_all();
      check("coal_n", 128'(wr_addr_log.size()), 128'd1);
      check("coal_addr", 128'(wr_addr_log[0]), 128'h7770);
      check("coal_data", wr_data_log[0], DD);

      // Read miss with a 3-cycle memory
      clear_logs();
      mem_lat   = 3;
      rd_cycles = 0;
      l2_req(1'b1, 16'h8883, '0, lat, data, pm);
      check("miss_rd_cycles", 128'(rd_cycles), 128'd3);
      check("miss_lat", 128'(lat), 128'd5);
      check("miss_rdata", data, rd_pattern(16'h8880));
      check("miss_addr", 128'(rd_addr_log[0]), 128'h8880);

      // Reset during a drain
      mem_lat  = 2;
      mem_hold = 1'b1;
      l2_req(1'b0, 16'h9990, DE, lat, data, pm);
      cycle();
      cycle();
      check("rstd_in_drain", 128'(pmem_write), 128'd1);
      rst = 1'b1;
      cycle();
      check("rstd_pmem_write", 128'(pmem_write), 128'd0);
      check("rstd_pmem_read", 128'(pmem_read), 128'd0);
      check("rstd_resp", 128'(l2_resp), 128'd0);
      check("rstd_pmem_addr", 128'(pmem_address), 128'd0);
      check("rstd_pmem_wdata", pmem_wdata, 128'd0);
      check("rstd_rdata", l2_rdata, 128'd0);
      check("rstd_empty", 128'(buf_empty), 128'd1);
      check("rstd_full", 128'(buf_full), 128'd0);
      rst      = 1'b0;
      mem_hold = 1'b0;
      clear_logs();
      repeat (5) cycle();
      check("rstd_no_drain", 128'(wr_addr_log.size()), 128'd0);
      check("rstd_idle_write", 128'(pmem_write), 128'd0);

      check("pmem_both_high", 128'(both_high), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
